mul_pipe_unit: RTL



---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_pp_stage.sv | 101 ++++++++++
 rtl/mul_pipe_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared op encodings and sign-correction helper
// for the three-stage pipelined multiplier.
package mul_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_TAG_W  = 4;

    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,
        MUL_HSS = 2'd1,
        MUL_HSU = 2'd2,
        MUL_HUU = 2'd3
    } mul_op_e;

    // {sgn1, sgn2}: operands whose sign weight must be
    // removed from the unsigned product
    function automatic logic [1:0] mul_sign_corr(
        input mul_op_e op,
        input logic    a_msb,
        input logic    b_msb
    );
        logic s1;
        logic s2;
        s1 = a_msb & ((op == MUL_HSS) | (op == MUL_HSU));
        s2 = b_msb & (op == MUL_HSS);
        return {s1, s2};
    endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// mul_pp_stage: first pipeline register, four half-width
// partial products plus operands and sideband.
module mul_pp_stage
    import mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W,
    parameter int HALF_W = DATA_W / 2,
    parameter int TAG_W  = MUL_TAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    input  logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] pp0_q,
    output logic [DATA_W-1:0] pp1_q,
    output logic [DATA_W-1:0] pp2_q,
    output logic [DATA_W-1:0] pp3_q,
    output logic [DATA_W-1:0] src1_q,
    output logic [DATA_W-1:0] src2_q,
    output logic [1:0]        op_q,
    output logic [TAG_W-1:0]  tag_q,
    output logic              sgn1_q,
    output logic              sgn2_q
);

    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [DATA_W-1:0] pp0_d, pp1_d, pp2_d, pp3_d;
    logic [DATA_W-1:0] src1_d, src2_d;
    logic [1:0]        op_d;
    logic [TAG_W-1:0]  tag_d;
    logic              sgn1_d, sgn2_d;
    logic [1:0]        corr;

    // Next state: fresh partial products on load, else hold
    always_comb begin
        a_lo = src1[HALF_W-1:0];
        a_hi = src1[DATA_W-1:HALF_W];
        b_lo = src2[HALF_W-1:0];
        b_hi = src2[DATA_W-1:HALF_W];
        corr = mul_sign_corr(mul_op_e'(op),
                             src1[DATA_W-1],
                             src2[DATA_W-1]);
        pp0_d  = pp0_q;
        pp1_d  = pp1_q;
        pp2_d  = pp2_q;
        pp3_d  = pp3_q;
        src1_d = src1_q;
        src2_d = src2_q;
        op_d   = op_q;
        tag_d  = tag_q;
        sgn1_d = sgn1_q;
        sgn2_d = sgn2_q;
        if (load) begin
            pp0_d  = {{HALF_W{1'b0}}, a_lo}
                   * {{HALF_W{1'b0}}, b_lo};
            pp1_d  = {{HALF_W{1'b0}}, a_lo}
                   * {{HALF_W{1'b0}}, b_hi};
            pp2_d  = {{HALF_W{1'b0}}, a_hi}
                   * {{HALF_W{1'b0}}, b_lo};
            pp3_d  = {{HALF_W{1'b0}}, a_hi}
                   * {{HALF_W{1'b0}}, b_hi};
            src1_d = src1;
            src2_d = src2;
            op_d   = op;
            tag_d  = tag;
            sgn1_d = corr[1];
            sgn2_d = corr[0];
        end
    end

    // Stage-1 registers with async clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp0_q  <= '0;
            pp1_q  <= '0;
            pp2_q  <= '0;
            pp3_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            op_q   <= '0;
            tag_q  <= '0;
            sgn1_q <= 1'b0;
            sgn2_q <= 1'b0;
        end else begin
            pp0_q  <= pp0_d;
            pp1_q  <= pp1_d;
            pp2_q  <= pp2_d;
            pp3_q  <= pp3_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            op_q   <= op_d;
            tag_q  <= tag_d;
            sgn1_q <= sgn1_d;
            sgn2_q <= sgn2_d;
        end
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: 3-stage multiplier (partial products, sum
// with sign correction, word select) with valid/ready flow.
module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W,
    parameter int HALF_W = DATA_W / 2,
    parameter int TAG_W  = MUL_TAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ZW = '0;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic r1, r2, r3;
    logic ld1, ld2, ld3;

    logic [DATA_W-1:0] pp0, pp1, pp2, pp3;
    logic [DATA_W-1:0] s1_src1, s1_src2;
    logic [1:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_sgn1, s1_sgn2;

    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [1:0]        op2_q, op2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [TAG_W-1:0]  tag3_q, tag3_d;

    // Ready chain: a stage loads when empty or draining
    always_comb begin
        r3       = ~v3_q | out_ready;
        r2       = ~v2_q | r3;
        r1       = ~v1_q | r2;
        in_ready = r1 & ~flush;
        ld1      = in_valid & in_ready;
        ld2      = r2 & v1_q & ~flush;
        ld3      = r3 & v2_q & ~flush;
    end

    // Valid bits advance with their stage; flush empties all
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else begin
            if (r1) v1_d = in_valid;
            if (r2) v2_d = v1_q;
            if (r3) v3_d = v2_q;
        end
    end

    mul_pp_stage #(
        .DATA_W (DATA_W),
        .HALF_W (HALF_W),
        .TAG_W  (TAG_W)
    ) u_s1 (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ld1),
        .src1    (in_src1),
        .src2    (in_src2),
        .op      (in_op),
        .tag     (in_tag),
        .pp0_q   (pp0),
        .pp1_q   (pp1),
        .pp2_q   (pp2),
        .pp3_q   (pp3),
        .src1_q  (s1_src1),
        .src2_q  (s1_src2),
        .op_q    (s1_op),
        .tag_q   (s1_tag),
        .sgn1_q  (s1_sgn1),
        .sgn2_q  (s1_sgn2)
    );

    // Stage 2: sum partial products, strip sign weights
    always_comb begin
        sum = {ZW, pp0}
            + ({ZW, pp1} << HALF_W)
            + ({ZW, pp2} << HALF_W)
            + {pp3, ZW};
        if (s1_sgn1) sum = sum - {s1_src2, ZW};
        if (s1_sgn2) sum = sum - {s1_src1, ZW};
        prod_d = ld2 ? sum : prod_q;
        op2_d  = ld2 ? s1_op : op2_q;
        tag2_d = ld2 ? s1_tag : tag2_q;
    end

    // Stage 3: pick low or high word of the product
    always_comb begin
        res_d  = res_q;
        tag3_d = tag3_q;
        if (ld3) begin
            res_d  = (op2_q == MUL_LO)
                   ? prod_q[DATA_W-1:0]
                   : prod_q[PROD_W-1:DATA_W];
            tag3_d = tag2_q;
        end
    end

    // Pipeline state registers with async clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            prod_q <= '0;
            op2_q  <= '0;
            tag2_q <= '0;
            res_q  <= '0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            prod_q <= prod_d;
            op2_q  <= op2_d;
            tag2_q <= tag2_d;
            res_q  <= res_d;
            tag3_q <= tag3_d;
        end
    end

    assign out_valid  = v3_q;
    assign out_result = res_q;
    assign out_tag    = tag3_q;

endmodule
